// File: rtl/hack_pkg.sv
// Shared definitions for the program counter: word type and PC command encoding.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } pc_cmd_e;

  // Fixed priority ret > call > load > inc > hold; reset is handled by the flops.
  function automatic pc_cmd_e encode_cmd(input logic ret, input logic call,
                                         input logic load, input logic inc);
    pc_cmd_e cmd;
    if (ret)       cmd = CMD_RET;
    else if (call) cmd = CMD_CALL;
    else if (load) cmd = CMD_LOAD;
    else if (inc)  cmd = CMD_INC;
    else           cmd = CMD_HOLD;
    return cmd;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Shallow LIFO of return addresses; push-when-full and pop-when-empty are no-ops.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;
  logic [PTR_W-1:0] wr_ptr, top_ptr;

  assign pop_ok  = pop & ~empty_q;
  assign push_ok = push & ~pop & ~full_q;
  assign wr_ptr  = count_q[PTR_W-1:0];
  // When full the low pointer bits wrap to zero, so count-1 still lands on DEPTH-1.
  assign top_ptr = count_q[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    count_d = count_q;
    if (pop_ok)       count_d = count_q - CNT_W'(1);
    else if (push_ok) count_d = count_q + CNT_W'(1);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr] <= data_in;
  end

  assign top   = mem_q[top_ptr];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/program_counter.sv
// Program counter with load/inc/hold plus call/ret through a hardware return stack.
module program_counter
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             overflow,
  output logic             underflow
);

  pc_cmd_e          cmd;
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus1;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full, stk_empty;

  assign cmd      = encode_cmd(ret, call, load, inc);
  assign pc_plus1 = pc_q + WIDTH'(1);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_return_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd == CMD_CALL),
    .pop     (cmd == CMD_RET),
    .data_in (pc_plus1),
    .top     (stk_top),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    case (cmd)
      CMD_RET: begin
        if (stk_empty) udf_d = 1'b1;
        else           pc_d  = stk_top;
      end
      // A call while full still jumps; only the return address is lost.
      CMD_CALL: begin
        pc_d = in;
        if (stk_full) ovf_d = 1'b1;
      end
      CMD_LOAD: pc_d = in;
      CMD_INC:  pc_d = pc_plus1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign out         = pc_q;
  assign stack_full  = stk_full;
  assign stack_empty = stk_empty;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule
